// File: rtl/st_ctrl_backend.sv
// Store back-end controller for CRAM: walks the ID/attribute/shared/data token
// stream, strobes the store datapath and returns a release token upstream.
//
//   state  | meaning
//   INIT   | idle, waiting for I_Req on a data block
//   ID     | capturing NUM_IDS ID words
//   ATTRIB | capturing the attribute word
//   SHARED | capturing the shared-data word
//   STORE  | writing data words until release token or final address
//   RLS    | returning the release token upstream
module st_ctrl_backend #(
   parameter int NUM_IDS      = 3,
   parameter int WIDTH_LENGTH = 12
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    I_Req,
   input  logic                    I_Valid,
   input  logic                    I_Stall,
   input  logic                    is_Data_Block,
   input  logic                    is_With_IDs,
   input  logic                    is_Shared,
   input  logic                    is_Rls,
   input  logic                    is_End_Store,
   output logic                    O_Store_IDs,
   output logic                    O_Set_Attrib,
   output logic                    O_Set_Shared,
   output logic                    O_Store,
   output logic                    O_First_Store,
   output logic                    O_Tail_Store,
   output logic                    O_Send_Rls,
   output logic [WIDTH_LENGTH-1:0] O_Length,
   output logic                    O_Busy
);

   localparam int IDW = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1;
   localparam logic [IDW-1:0]          ID_LAST = IDW'(NUM_IDS - 1);
   localparam logic [IDW-1:0]          ID_ONE  = IDW'(1);
   localparam logic [WIDTH_LENGTH-1:0] LEN_ONE = WIDTH_LENGTH'(1);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_ID     = 3'd1,
      S_ATTRIB = 3'd2,
      S_SHARED = 3'd3,
      S_STORE  = 3'd4,
      S_RLS    = 3'd5
   } state_t;

   state_t                  state_q, state_d;
   logic [IDW-1:0]          id_cnt_q, id_cnt_d;
   logic [WIDTH_LENGTH-1:0] len_q, len_d;
   logic                    first_q, first_d;
   logic                    acc;

   assign acc = I_Valid & ~I_Stall;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_INIT;
         id_cnt_q <= '0;
         len_q    <= '0;
         first_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         id_cnt_q <= id_cnt_d;
         len_q    <= len_d;
         first_q  <= first_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      id_cnt_d      = id_cnt_q;
      len_d         = len_q;
      first_d       = first_q;
      O_Store_IDs   = 1'b0;
      O_Set_Attrib  = 1'b0;
      O_Set_Shared  = 1'b0;
      O_Store       = 1'b0;
      O_First_Store = 1'b0;
      O_Tail_Store  = 1'b0;
      O_Send_Rls    = 1'b0;
      case (state_q)
         S_INIT: begin
            if (I_Req) begin
               len_d = '0;
               if (is_Data_Block) state_d = is_With_IDs ? S_ID : S_ATTRIB;
            end
         end
         S_ID: begin
            if (acc) begin
               if (is_Rls) begin
                  id_cnt_d = '0;
                  state_d  = S_RLS;
               end else begin
                  O_Store_IDs = 1'b1;
                  if (id_cnt_q == ID_LAST) begin
                     id_cnt_d = '0;
                     state_d  = S_ATTRIB;
                  end else begin
                     id_cnt_d = id_cnt_q + ID_ONE;
                  end
               end
            end
         end
         S_ATTRIB: begin
            if (acc) begin
               if (is_Rls) begin
                  state_d = S_RLS;
               end else begin
                  O_Set_Attrib = 1'b1;
                  if (is_Shared) begin
                     state_d = S_SHARED;
                  end else begin
                     first_d = 1'b1;
                     state_d = S_STORE;
                  end
               end
            end
         end
         S_SHARED: begin
            if (acc) begin
               if (is_Rls) begin
                  state_d = S_RLS;
               end else begin
                  O_Set_Shared = 1'b1;
                  first_d      = 1'b1;
                  state_d      = S_STORE;
               end
            end
         end
         S_STORE: begin
            // The release token only ends the block; it is never written.
            if (acc && !is_Rls) begin
               O_Store       = 1'b1;
               O_First_Store = first_q;
               O_Tail_Store  = is_End_Store;
               first_d       = 1'b0;
               if (len_q != '1) len_d = len_q + LEN_ONE;
               if (is_End_Store) state_d = S_RLS;
            end else if (acc && is_Rls) begin
               state_d = S_RLS;
            end
         end
         S_RLS: begin
            O_Send_Rls = ~I_Stall;
            if (!I_Stall) state_d = S_INIT;
         end
         default: state_d = S_INIT;
      endcase
   end

   assign O_Length = len_q;
   assign O_Busy   = (state_q != S_INIT);

endmodule

// File: tb/tb_st_ctrl_backend.sv
// Directed bench for st_ctrl_backend: each task walks a cycle table of inputs
// against hand-derived strobes, busy flag and stored-word count.
module tb_st_ctrl_backend;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        I_Req = 1'b0, I_Valid = 1'b0, I_Stall = 1'b0;
   logic        is_Data_Block = 1'b0, is_With_IDs = 1'b0, is_Shared = 1'b0;
   logic        is_Rls = 1'b0, is_End_Store = 1'b0;
   logic        O_Store_IDs, O_Set_Attrib, O_Set_Shared, O_Store;
   logic        O_First_Store, O_Tail_Store, O_Send_Rls, O_Busy;
   logic [11:0] O_Length;
   logic [6:0]  strb;

   int checks   = 0;
   int failures = 0;

   st_ctrl_backend #(.NUM_IDS(3), .WIDTH_LENGTH(12)) dut (
      .clock(clock), .reset(reset), .I_Req(I_Req), .I_Valid(I_Valid),
      .I_Stall(I_Stall), .is_Data_Block(is_Data_Block), .is_With_IDs(is_With_IDs),
      .is_Shared(is_Shared), .is_Rls(is_Rls), .is_End_Store(is_End_Store),
      .O_Store_IDs(O_Store_IDs), .O_Set_Attrib(O_Set_Attrib),
      .O_Set_Shared(O_Set_Shared), .O_Store(O_Store), .O_First_Store(O_First_Store),
      .O_Tail_Store(O_Tail_Store), .O_Send_Rls(O_Send_Rls), .O_Length(O_Length),
      .O_Busy(O_Busy)
   );

   always #5 clock = ~clock;

   // strobe order: Store_IDs Set_Attrib Set_Shared Store First Tail Send_Rls
   assign strb = {O_Store_IDs, O_Set_Attrib, O_Set_Shared, O_Store,
                  O_First_Store, O_Tail_Store, O_Send_Rls};

   // input vector order: Req DataBlock WithIDs | Valid Stall Rls Shared EndStore
   task automatic set_inputs(input logic [7:0] v);
      {I_Req, is_Data_Block, is_With_IDs, I_Valid, I_Stall, is_Rls, is_Shared,
       is_End_Store} = v;
   endtask

   task automatic test_reset();
      set_inputs(8'b000_00000);
      reset = 1'b0;
      #3;
      checks++;
      if ({strb, O_Busy} !== 8'b0000000_0) begin
         failures++;
         $display("FAIL reset_outputs: got %b want %b", {strb, O_Busy}, 8'b0);
      end
      checks++;
      if (O_Length !== 12'd0) begin
         failures++;
         $display("FAIL reset_length: got %0d want 0", O_Length);
      end
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_plain_store();
      logic [7:0] vi [9];
      logic [7:0] vo [9];
      int         vl [9];
      vi = '{8'b110_00000, 8'b000_10000, 8'b000_10000, 8'b000_10000, 8'b000_10000,
             8'b000_10000, 8'b000_10100, 8'b000_00000, 8'b000_00000};
      vo = '{8'b0000000_0, 8'b0100000_1, 8'b0001100_1, 8'b0001000_1, 8'b0001000_1,
             8'b0001000_1, 8'b0000000_1, 8'b0000001_1, 8'b0000000_0};
      vl = '{0, 0, 0, 1, 2, 3, 4, 4, 4};
      for (int k = 0; k < 9; k++) begin
         set_inputs(vi[k]);
         @(negedge clock);
         checks++;
         if ({strb, O_Busy} !== vo[k]) begin
            failures++;
            $display("FAIL plain_strobes[%0d]: got %b want %b", k, {strb, O_Busy}, vo[k]);
         end
         checks++;
         if (O_Length !== 12'(vl[k])) begin
            failures++;
            $display("FAIL plain_length[%0d]: got %0d want %0d", k, O_Length, vl[k]);
         end
         @(posedge clock);
         #1;
      end
   endtask

   task automatic test_ids_shared();
      logic [7:0] vi [11];
      logic [7:0] vo [11];
      int         vl [11];
      vi = '{8'b111_00000, 8'b000_10000, 8'b000_10000, 8'b000_10000, 8'b000_10010,
             8'b000_10000, 8'b000_10000, 8'b000_10000, 8'b000_10100, 8'b000_00000,
             8'b000_00000};
      vo = '{8'b0000000_0, 8'b1000000_1, 8'b1000000_1, 8'b1000000_1, 8'b0100000_1,
             8'b0010000_1, 8'b0001100_1, 8'b0001000_1, 8'b0000000_1, 8'b0000001_1,
             8'b0000000_0};
      vl = '{4, 0, 0, 0, 0, 0, 0, 1, 2, 2, 2};
      for (int k = 0; k < 11; k++) begin
         set_inputs(vi[k]);
         @(negedge clock);
         checks++;
         if ({strb, O_Busy} !== vo[k]) begin
            failures++;
            $display("FAIL ids_strobes[%0d]: got %b want %b", k, {strb, O_Busy}, vo[k]);
         end
         checks++;
         if (O_Length !== 12'(vl[k])) begin
            failures++;
            $display("FAIL ids_length[%0d]: got %0d want %0d", k, O_Length, vl[k]);
         end
         @(posedge clock);
         #1;
      end
   endtask

   // Stall for three cycles mid-STORE, then a stalled release token, then a stalled RLS.
   task automatic test_stall();
      logic [7:0] vi [12];
      logic [7:0] vo [12];
      int         vl [12];
      vi = '{8'b110_00000, 8'b000_10000, 8'b000_10000, 8'b000_11000, 8'b000_11000,
             8'b000_11000, 8'b000_10000, 8'b000_11100, 8'b000_10100, 8'b000_01000,
             8'b000_00000, 8'b000_00000};
      vo = '{8'b0000000_0, 8'b0100000_1, 8'b0001100_1, 8'b0000000_1, 8'b0000000_1,
             8'b0000000_1, 8'b0001000_1, 8'b0000000_1, 8'b0000000_1, 8'b0000000_1,
             8'b0000001_1, 8'b0000000_0};
      vl = '{2, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2};
      for (int k = 0; k < 12; k++) begin
         set_inputs(vi[k]);
         @(negedge clock);
         checks++;
         if ({strb, O_Busy} !== vo[k]) begin
            failures++;
            $display("FAIL stall_strobes[%0d]: got %b want %b", k, {strb, O_Busy}, vo[k]);
         end
         checks++;
         if (O_Length !== 12'(vl[k])) begin
            failures++;
            $display("FAIL stall_length[%0d]: got %0d want %0d", k, O_Length, vl[k]);
         end
         @(posedge clock);
         #1;
      end
   endtask

   task automatic test_end_store();
      logic [7:0] vi [10];
      logic [7:0] vo [10];
      int         vl [10];
      vi = '{8'b110_00000, 8'b000_10000, 8'b000_10000, 8'b000_10000, 8'b000_10000,
             8'b000_10000, 8'b000_10001, 8'b000_00000, 8'b000_10100, 8'b000_00000};
      vo = '{8'b0000000_0, 8'b0100000_1, 8'b0001100_1, 8'b0001000_1, 8'b0001000_1,
             8'b0001000_1, 8'b0001010_1, 8'b0000001_1, 8'b0000000_0, 8'b0000000_0};
      vl = '{2, 0, 0, 1, 2, 3, 4, 5, 5, 5};
      for (int k = 0; k < 10; k++) begin
         set_inputs(vi[k]);
         @(negedge clock);
         checks++;
         if ({strb, O_Busy} !== vo[k]) begin
            failures++;
            $display("FAIL end_strobes[%0d]: got %b want %b", k, {strb, O_Busy}, vo[k]);
         end
         checks++;
         if (O_Length !== 12'(vl[k])) begin
            failures++;
            $display("FAIL end_length[%0d]: got %0d want %0d", k, O_Length, vl[k]);
         end
         @(posedge clock);
         #1;
      end
   endtask

   task automatic test_rls_in_attrib();
      logic [7:0] vi [4];
      logic [7:0] vo [4];
      int         vl [4];
      vi = '{8'b110_00000, 8'b000_10100, 8'b000_00000, 8'b000_00000};
      vo = '{8'b0000000_0, 8'b0000000_1, 8'b0000001_1, 8'b0000000_0};
      vl = '{5, 0, 0, 0};
      for (int k = 0; k < 4; k++) begin
         set_inputs(vi[k]);
         @(negedge clock);
         checks++;
         if ({strb, O_Busy} !== vo[k]) begin
            failures++;
            $display("FAIL abort_strobes[%0d]: got %b want %b", k, {strb, O_Busy}, vo[k]);
         end
         checks++;
         if (O_Length !== 12'(vl[k])) begin
            failures++;
            $display("FAIL abort_length[%0d]: got %0d want %0d", k, O_Length, vl[k]);
         end
         @(posedge clock);
         #1;
      end
   endtask

   task automatic test_reset_mid_store();
      logic [7:0] vi [10];
      logic [7:0] vo [10];
      int         vl [10];
      // rows 0-3: two words into STORE; rows 4-9: clean restart after reset
      vi = '{8'b110_00000, 8'b000_10000, 8'b000_10000, 8'b000_10000,
             8'b110_00000, 8'b000_10000, 8'b000_10000, 8'b000_10100, 8'b000_00000,
             8'b000_00000};
      vo = '{8'b0000000_0, 8'b0100000_1, 8'b0001100_1, 8'b0001000_1,
             8'b0000000_0, 8'b0100000_1, 8'b0001100_1, 8'b0000000_1, 8'b0000001_1,
             8'b0000000_0};
      vl = '{0, 0, 0, 1, 0, 0, 0, 1, 1, 1};
      for (int k = 0; k < 10; k++) begin
         if (k == 4) begin
            set_inputs(8'b000_10000);
            #1;
            checks++;
            if ({strb, O_Busy} !== 8'b0001000_1) begin
               failures++;
               $display("FAIL pre_reset_store: got %b want %b", {strb, O_Busy}, 8'b0001000_1);
            end
            reset = 1'b0;
            #1;
            checks++;
            if ({strb, O_Busy} !== 8'b0000000_0) begin
               failures++;
               $display("FAIL midreset_outputs: got %b want %b", {strb, O_Busy}, 8'b0);
            end
            checks++;
            if (O_Length !== 12'd0) begin
               failures++;
               $display("FAIL midreset_length: got %0d want 0", O_Length);
            end
            @(negedge clock);
            reset = 1'b1;
            @(posedge clock);
            #1;
         end
         set_inputs(vi[k]);
         @(negedge clock);
         checks++;
         if ({strb, O_Busy} !== vo[k]) begin
            failures++;
            $display("FAIL rst_strobes[%0d]: got %b want %b", k, {strb, O_Busy}, vo[k]);
         end
         checks++;
         if (O_Length !== 12'(vl[k])) begin
            failures++;
            $display("FAIL rst_length[%0d]: got %0d want %0d", k, O_Length, vl[k]);
         end
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_plain_store();
      test_ids_shared();
      test_stall();
      test_end_store();
      test_rls_in_attrib();
      test_reset_mid_store();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
